data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port arbiter that shares the single-port byte-addressed data memory between the core load/store unit (port 0) and a secondary master (port 1, e.g. DMA or debug loader). It grants one request per cycle using round-robin priority with an optional lock for atomic sequences. It range-checks each access, drives the memory's write-enable, byte-op, address and write-data inputs, and returns registered read data with a valid strobe.

## Interface
- DATA_WIDTH, 32, data and address width
- START_ADDRESS, 32'h10000, lowest legal data address
- END_ADDRESS, 32'h1FFFF, highest legal data address
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- req0_i / req1_i  in  1  access request, port 0 / port 1
- lock0_i / lock1_i  in  1  hold ownership after this access, port 0 / port 1
- we0_i / we1_i  in  1  1 = store, 0 = load
- byte_op0_i / byte_op1_i  in  1  1 = byte (SB/LBU), 0 = word
- addr0_i / addr1_i  in  DATA_WIDTH  byte address
- wd0_i / wd1_i  in  DATA_WIDTH  store data
- gnt0_o / gnt1_o  out  1  request accepted this cycle (combinational)
- rvalid0_o / rvalid1_o  out  1  rdata valid for the port's load granted in the previous cycle
- rdata_o  out  DATA_WIDTH  registered load data, shared by both ports
- err_o  out  1  pulse, one cycle after a granted out-of-range or misaligned access
- mem_we_o  out  1  to memory write enable
- mem_byte_op_o  out  1  to memory byte-op select
- mem_addr_o  out  DATA_WIDTH  to memory address
- mem_wd_o  out  DATA_WIDTH  to memory write data
- mem_rd_i  in  DATA_WIDTH  from memory combinational read data

## Operation
- FSM states: IDLE (no owner), LOCK0 (port 0 owns), LOCK1 (port 1 owns). Priority pointer prio: 0 favours port 0, 1 favours port 1.
- IDLE: if only one req, grant it; if both, grant port prio. After a grant to port k, prio <= ~k. If granted with lock_k=1, go to LOCKk.
- LOCKk: only port k can be granted; the other port's req waits (gnt low). Grant of k with lock_k=0 -> IDLE, prio <= ~k. Cycle with req_k=0 -> IDLE (lock released, prio unchanged, no grant that cycle to either port).
- Granted port's we/byte_op/addr/wd drive mem_* combinationally. No grant: mem_we_o=0, mem_byte_op_o=0, mem_addr_o=0, mem_wd_o=0.
- Range check: illegal if addr < START_ADDRESS, or addr > END_ADDRESS (byte), or addr+3 > END_ADDRESS (word). Misaligned: word access with addr[1:0] != 0. Illegal or misaligned access is still granted; mem_we_o forced 0; load returns rdata_o=0; err_o=1 next cycle.
- Load data: on grant of a legal load, rdata_o <= mem_rd_i and rvalid_k_o <= 1 at the rising edge ending the grant cycle. Stores never raise rvalid.
- Requester holds req and all fields stable until gnt; dropping req before gnt is permitted (request withdrawn, no side effects).

## Timing
- Grant latency: 0 cycles (gnt same cycle as req when port wins). Load latency: rdata/rvalid one cycle after grant. Throughput: one access per cycle total.
- Memory commits writes on the falling edge within the grant cycle; a load granted in the next cycle, from either port, returns the new data.
- Reset (rst_n=0 at rising edge): state IDLE, prio 0, rdata_o=0, rvalid0_o=rvalid1_o=0, err_o=0. gnt outputs and mem_we_o are 0 whenever rst_n=0, regardless of req.
- Reset asserted mid-lock: lock dropped, returns to IDLE; an access presented in the reset cycle is not performed.
- rvalid_k_o and err_o are single-cycle pulses unless back-to-back grants occur.

## Test plan
- Reset then port 0 word store 0xDEADBEEF to 0x10000, then port 1 word load 0x10000 next cycle -> gnt0 then gnt1, rvalid1_o=1 with rdata_o=0xDEADBEEF one cycle after gnt1.
- Both ports request every cycle for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; no cycle grants both.
- Port 1 lock1_i=1 for 3 accesses while port 0 requests continuously -> gnt1 three cycles, gnt0 low throughout, gnt0 in cycle after the lock1_i=0 access.
- Port 0 word load at 0x1FFFE and byte store 0xAB at 0x0FFFF -> both granted, mem_we_o=0, rdata_o=0, err_o pulses once per access; memory unchanged.
- Port 0 byte store 0x5A at 0x10003, then word load 0x10000 -> rdata_o[31:24]=0x5A; word load at 0x10001 -> err_o=1, rdata_o=0.
- Assert rst_n=0 during LOCK0 with both req high -> no grants, mem_we_o=0; after release, both req -> port 0 granted first (prio reset to 0).

Source files
------------

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Port 0 (core LSU) and port 1 (DMA/debug) request signals, the grant and
// load-response signals back to them, and the memory-side drive signals.
// slave  : the arbiter (consumes requests and mem_rd_i, drives grants/mem_*).
// master : the environment (requesters plus memory).
interface data_memory_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0_i, req1_i;
  logic                  lock0_i, lock1_i;
  logic                  we0_i, we1_i;
  logic                  byte_op0_i, byte_op1_i;
  logic [DATA_WIDTH-1:0] addr0_i, addr1_i;
  logic [DATA_WIDTH-1:0] wd0_i, wd1_i;
  logic                  gnt0_o, gnt1_o;
  logic                  rvalid0_o, rvalid1_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;
  logic                  mem_we_o;
  logic                  mem_byte_op_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wd_o;
  logic [DATA_WIDTH-1:0] mem_rd_i;

  modport slave (
    input  req0_i, req1_i, lock0_i, lock1_i, we0_i, we1_i,
           byte_op0_i, byte_op1_i, addr0_i, addr1_i, wd0_i, wd1_i, mem_rd_i,
    output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o, err_o,
           mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
  );

  modport master (
    output req0_i, req1_i, lock0_i, lock1_i, we0_i, we1_i,
           byte_op0_i, byte_op1_i, addr0_i, addr1_i, wd0_i, wd1_i, mem_rd_i,
    input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o, err_o,
           mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port byte-addressed data
// memory, with per-port lock for atomic sequences and range/alignment check.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - data_memory_arbiter_if.slave: requests in, combinational grants,
//           registered rdata/rvalid/err out, memory drive signals out.
module data_memory_arbiter #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 32'h10000,
  parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 32'h1FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                state;
  logic                  prio;
  logic                  gnt0, gnt1, any_gnt;
  logic                  sel_we, sel_byte;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wd;
  logic [DATA_WIDTH:0]   last_byte;
  logic                  bad;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid0_q, rvalid1_q, err_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (bus.req0_i && (!bus.req1_i || !prio)) gnt0 = 1'b1;
          else if (bus.req1_i)                      gnt1 = 1'b1;
        end
        LOCK0:   gnt0 = bus.req0_i;
        LOCK1:   gnt1 = bus.req1_i;
        default: ;
      endcase
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign sel_we   = gnt1 ? bus.we1_i      : bus.we0_i;
  assign sel_byte = gnt1 ? bus.byte_op1_i : bus.byte_op0_i;
  assign sel_addr = gnt1 ? bus.addr1_i    : bus.addr0_i;
  assign sel_wd   = gnt1 ? bus.wd1_i      : bus.wd0_i;

  // Address of the last byte touched (+3 for words), one bit wider so a
  // word near the top of the address space cannot wrap past the check.
  assign last_byte = {1'b0, sel_addr} + {{(DATA_WIDTH-1){1'b0}}, ~sel_byte, ~sel_byte};
  assign bad = (sel_addr < START_ADDRESS) ||
               (last_byte > {1'b0, END_ADDRESS}) ||
               (!sel_byte && (sel_addr[1:0] != 2'b00));

  assign bus.gnt0_o        = gnt0;
  assign bus.gnt1_o        = gnt1;
  assign bus.mem_we_o      = any_gnt & sel_we & ~bad;
  assign bus.mem_byte_op_o = any_gnt & sel_byte;
  assign bus.mem_addr_o    = any_gnt ? sel_addr : '0;
  assign bus.mem_wd_o      = any_gnt ? sel_wd   : '0;
  assign bus.rdata_o       = rdata_q;
  assign bus.rvalid0_o     = rvalid0_q;
  assign bus.rvalid1_o     = rvalid1_q;
  assign bus.err_o         = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 & ~bus.we0_i;
      rvalid1_q <= gnt1 & ~bus.we1_i;
      err_q     <= any_gnt & bad;
      // A rejected load still answers, with zero data.
      if (any_gnt && !sel_we) rdata_q <= bad ? '0 : bus.mem_rd_i;

      case (state)
        IDLE: begin
          if (gnt0) begin
            prio <= 1'b1;
            if (bus.lock0_i) state <= LOCK0;
          end else if (gnt1) begin
            prio <= 1'b0;
            if (bus.lock1_i) state <= LOCK1;
          end
        end
        LOCK0: begin
          if (!bus.req0_i) state <= IDLE;
          else if (!bus.lock0_i) begin
            state <= IDLE;
            prio  <= 1'b1;
          end
        end
        LOCK1: begin
          if (!bus.req1_i) state <= IDLE;
          else if (!bus.lock1_i) begin
            state <= IDLE;
            prio  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  localparam int unsigned DW     = 32;
  localparam logic [31:0] START  = 32'h10000;
  localparam logic [31:0] END_A  = 32'h1FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_arbiter_if #(.DATA_WIDTH(DW)) bus();

  data_memory_arbiter #(
    .DATA_WIDTH(DW), .START_ADDRESS(START), .END_ADDRESS(END_A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Environment memory (driven by DUT mem_* outputs) and the reference copy
  // maintained purely from the expected behaviour.
  logic [7:0] env_mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  int unsigned mem_epoch = 0;

  function automatic logic [7:0] env_byte(logic [31:0] a);
    if (a >= START && a <= END_A) return env_mem[16'(a - START)];
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(logic [31:0] a);
    if (a >= START && a <= END_A) return ref_mem[16'(a - START)];
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (bus.mem_we_o) begin
      if (bus.mem_byte_op_o) begin
        if (bus.mem_addr_o >= START && bus.mem_addr_o <= END_A)
          env_mem[16'(bus.mem_addr_o - START)] <= bus.mem_wd_o[7:0];
      end else begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_addr_o + 32'(i) >= START && bus.mem_addr_o + 32'(i) <= END_A)
            env_mem[16'(bus.mem_addr_o + 32'(i) - START)] <= bus.mem_wd_o[8*i +: 8];
      end
      mem_epoch <= mem_epoch + 1;
    end
  end

  always @(bus.mem_addr_o or bus.mem_byte_op_o or mem_epoch) begin
    if (bus.mem_byte_op_o) bus.mem_rd_i = {24'h0, env_byte(bus.mem_addr_o)};
    else bus.mem_rd_i = {env_byte(bus.mem_addr_o + 32'd3), env_byte(bus.mem_addr_o + 32'd2),
                         env_byte(bus.mem_addr_o + 32'd1), env_byte(bus.mem_addr_o)};
  end

  function automatic bit is_bad(logic [31:0] a, bit b);
    longint la, last;
    la   = longint'(a);
    last = la + (b ? 0 : 3);
    return (la < longint'(START)) || (last > longint'(END_A)) || (!b && (a % 4 != 0));
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a, bit b);
    if (b) return {24'h0, ref_byte(a)};
    return {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(bit req, bit lock, bit we, bit b, logic [31:0] a, logic [31:0] wd);
    bus.req0_i = req; bus.lock0_i = lock; bus.we0_i = we;
    bus.byte_op0_i = b; bus.addr0_i = a; bus.wd0_i = wd;
  endtask

  task automatic set_p1(bit req, bit lock, bit we, bit b, logic [31:0] a, logic [31:0] wd);
    bus.req1_i = req; bus.lock1_i = lock; bus.we1_i = we;
    bus.byte_op1_i = b; bus.addr1_i = a; bus.wd1_i = wd;
  endtask

  task automatic set_idle();
    set_p0(0, 0, 0, 0, '0, '0);
    set_p1(0, 0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_idle(); tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_p0(1, 1, 1, 0, 32'h10000, 32'h12345678);
    set_p1(1, 0, 1, 0, 32'h10004, 32'h87654321);
    #3;
    checks++; if (bus.gnt0_o !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b expected 0", bus.gnt0_o); end
    checks++; if (bus.gnt1_o !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b expected 0", bus.gnt1_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we_o); end
    tick();
    checks++; if (bus.rvalid0_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid0: got %b expected 0", bus.rvalid0_o); end
    checks++; if (bus.rvalid1_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid1: got %b expected 0", bus.rvalid1_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata_o); end
    set_idle(); rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    set_p0(1, 0, 1, 0, 32'h10000, 32'hDEADBEEF);
    #3;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL sl_gnt0: got %b expected 1", bus.gnt0_o); end
    checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL sl_mem_we: got %b expected 1", bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 32'h10000) begin errors++; $display("FAIL sl_mem_addr: got %h expected 10000", bus.mem_addr_o); end
    checks++; if (bus.mem_wd_o !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_mem_wd: got %h expected deadbeef", bus.mem_wd_o); end
    tick();
    checks++; if (bus.rvalid0_o !== 1'b0) begin errors++; $display("FAIL sl_store_rvalid: got %b expected 0", bus.rvalid0_o); end
    set_p0(0, 0, 0, 0, '0, '0);
    set_p1(1, 0, 0, 0, 32'h10000, '0);
    #3;
    checks++; if (bus.gnt1_o !== 1'b1) begin errors++; $display("FAIL sl_gnt1: got %b expected 1", bus.gnt1_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL sl_load_we: got %b expected 0", bus.mem_we_o); end
    tick();
    checks++; if (bus.rvalid1_o !== 1'b1) begin errors++; $display("FAIL sl_rvalid1: got %b expected 1", bus.rvalid1_o); end
    checks++; if (bus.rvalid0_o !== 1'b0) begin errors++; $display("FAIL sl_rvalid0: got %b expected 0", bus.rvalid0_o); end
    checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_rdata: got %h expected deadbeef", bus.rdata_o); end
    set_idle(); tick();
    checks++; if (bus.rvalid1_o !== 1'b0) begin errors++; $display("FAIL sl_rvalid_pulse: got %b expected 0", bus.rvalid1_o); end
  endtask

  task automatic test_alternate();
    do_reset();
    set_p0(1, 0, 0, 0, 32'h10000, '0);
    set_p1(1, 0, 0, 0, 32'h10000, '0);
    for (int i = 0; i < 6; i++) begin
      #3;
      checks++; if (bus.gnt0_o !== ((i % 2) == 0)) begin errors++; $display("FAIL alt_gnt0[%0d]: got %b expected %b", i, bus.gnt0_o, (i % 2) == 0); end
      checks++; if (bus.gnt1_o !== ((i % 2) == 1)) begin errors++; $display("FAIL alt_gnt1[%0d]: got %b expected %b", i, bus.gnt1_o, (i % 2) == 1); end
      tick();
    end
    set_idle(); tick();
  endtask

  task automatic test_lock();
    set_p0(1, 0, 0, 0, 32'h10000, '0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_p1(1, (i < 2), 0, 0, 32'h10000, '0);
      #3;
      checks++; if (bus.gnt1_o !== 1'b1) begin errors++; $display("FAIL lock_gnt1[%0d]: got %b expected 1", i, bus.gnt1_o); end
      checks++; if (bus.gnt0_o !== 1'b0) begin errors++; $display("FAIL lock_gnt0[%0d]: got %b expected 0", i, bus.gnt0_o); end
      tick();
      checks++; if (bus.rvalid1_o !== 1'b1) begin errors++; $display("FAIL lock_rvalid1[%0d]: got %b expected 1", i, bus.rvalid1_o); end
    end
    set_p1(0, 0, 0, 0, '0, '0);
    #3;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL lock_after_gnt0: got %b expected 1", bus.gnt0_o); end
    tick();
    set_idle(); tick();
  endtask

  task automatic test_range();
    set_p0(1, 0, 0, 0, 32'h1FFFE, '0);
    #3;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL rng_load_gnt: got %b expected 1", bus.gnt0_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rng_load_we: got %b expected 0", bus.mem_we_o); end
    tick();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL rng_load_err: got %b expected 1", bus.err_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL rng_load_rdata: got %h expected 0", bus.rdata_o); end
    set_p0(1, 0, 1, 1, 32'h0FFFF, 32'h000000AB);
    #3;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL rng_store_gnt: got %b expected 1", bus.gnt0_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rng_store_we: got %b expected 0", bus.mem_we_o); end
    tick();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL rng_store_err: got %b expected 1", bus.err_o); end
    set_idle(); tick();
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rng_err_pulse: got %b expected 0", bus.err_o); end
    set_p0(1, 0, 0, 0, 32'h10000, '0);
    tick();
    checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rng_mem_unchanged: got %h expected deadbeef", bus.rdata_o); end
    set_idle(); tick();
  endtask

  task automatic test_byte();
    set_p0(1, 0, 1, 1, 32'h10003, 32'h0000005A);
    #3;
    checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL byte_we: got %b expected 1", bus.mem_we_o); end
    checks++; if (bus.mem_byte_op_o !== 1'b1) begin errors++; $display("FAIL byte_op: got %b expected 1", bus.mem_byte_op_o); end
    tick();
    set_p0(1, 0, 0, 0, 32'h10000, '0);
    tick();
    checks++; if (bus.rdata_o[31:24] !== 8'h5A) begin errors++; $display("FAIL byte_lane: got %h expected 5a", bus.rdata_o[31:24]); end
    checks++; if (bus.rdata_o !== 32'h5AADBEEF) begin errors++; $display("FAIL byte_word: got %h expected 5aadbeef", bus.rdata_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL byte_err: got %b expected 0", bus.err_o); end
    set_p0(1, 0, 0, 0, 32'h10001, '0);
    tick();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", bus.err_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h expected 0", bus.rdata_o); end
    set_idle(); tick();
  endtask

  task automatic test_reset_lock();
    set_p0(1, 1, 0, 0, 32'h10000, '0);
    #3;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL rl_lock_gnt0: got %b expected 1", bus.gnt0_o); end
    tick();
    rst_n = 1'b0;
    set_p0(1, 1, 1, 0, 32'h10000, 32'h11111111);
    set_p1(1, 0, 1, 0, 32'h10000, 32'h22222222);
    #3;
    checks++; if (bus.gnt0_o !== 1'b0) begin errors++; $display("FAIL rl_rst_gnt0: got %b expected 0", bus.gnt0_o); end
    checks++; if (bus.gnt1_o !== 1'b0) begin errors++; $display("FAIL rl_rst_gnt1: got %b expected 0", bus.gnt1_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rl_rst_we: got %b expected 0", bus.mem_we_o); end
    tick();
    rst_n = 1'b1;
    set_p0(1, 0, 0, 0, 32'h10000, '0);
    set_p1(1, 0, 0, 0, 32'h10000, '0);
    #3;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL rl_first_gnt0: got %b expected 1", bus.gnt0_o); end
    checks++; if (bus.gnt1_o !== 1'b0) begin errors++; $display("FAIL rl_first_gnt1: got %b expected 0", bus.gnt1_o); end
    tick();
    checks++; if (bus.rdata_o !== 32'h5AADBEEF) begin errors++; $display("FAIL rl_no_store: got %h expected 5aadbeef", bus.rdata_o); end
    set_idle(); tick();
  endtask

  task automatic draw(output bit req, output bit lock, output bit we, output bit b,
                      output logic [31:0] a, output logic [31:0] wd);
    int unsigned r;
    req  = ($urandom_range(0, 2) != 0);
    lock = ($urandom_range(0, 3) == 0);
    we   = $urandom_range(0, 1) == 1;
    b    = $urandom_range(0, 1) == 1;
    wd   = $urandom;
    r    = $urandom_range(0, 9);
    if (r <= 5) begin
      a = 32'h1F000 + 32'($urandom_range(0, 4095));
      if (!b && $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
    end else if (r <= 7) a = 32'h1FFF8 + 32'($urandom_range(0, 15));
    else if (r == 8)     a = 32'h0FFF0 + 32'($urandom_range(0, 15));
    else                 a = $urandom;
  endtask

  task automatic test_random();
    bit          p_req [2], p_lock [2], p_we [2], p_b [2];
    logic [31:0] p_a [2], p_wd [2];
    int          owner, g;
    bit          prio, bad, exp_rv0, exp_rv1, exp_err;
    logic [31:0] exp_rdata, a;
    do_reset();
    owner = -1; prio = 1'b0; exp_rdata = '0;
    for (int k = 0; k < 2; k++) draw(p_req[k], p_lock[k], p_we[k], p_b[k], p_a[k], p_wd[k]);
    for (int n = 0; n < 400; n++) begin
      set_p0(p_req[0], p_lock[0], p_we[0], p_b[0], p_a[0], p_wd[0]);
      set_p1(p_req[1], p_lock[1], p_we[1], p_b[1], p_a[1], p_wd[1]);
      if (owner >= 0)               g = p_req[owner] ? owner : -1;
      else if (p_req[0] && p_req[1]) g = int'(prio);
      else if (p_req[0])            g = 0;
      else if (p_req[1])            g = 1;
      else                          g = -1;
      bad = (g >= 0) ? is_bad(p_a[g], p_b[g]) : 1'b0;
      #3;
      checks++; if (bus.gnt0_o !== (g == 0)) begin errors++; $display("FAIL rnd_gnt0[%0d]: got %b expected %b", n, bus.gnt0_o, g == 0); end
      checks++; if (bus.gnt1_o !== (g == 1)) begin errors++; $display("FAIL rnd_gnt1[%0d]: got %b expected %b", n, bus.gnt1_o, g == 1); end
      if (g >= 0) begin
        checks++; if (bus.mem_we_o !== (p_we[g] && !bad)) begin errors++; $display("FAIL rnd_mem_we[%0d]: got %b expected %b", n, bus.mem_we_o, p_we[g] && !bad); end
        checks++; if (bus.mem_addr_o !== p_a[g]) begin errors++; $display("FAIL rnd_mem_addr[%0d]: got %h expected %h", n, bus.mem_addr_o, p_a[g]); end
        if (p_we[g] && !bad) begin
          checks++; if (bus.mem_wd_o !== p_wd[g]) begin errors++; $display("FAIL rnd_mem_wd[%0d]: got %h expected %h", n, bus.mem_wd_o, p_wd[g]); end
        end
      end else begin
        checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rnd_idle_we[%0d]: got %b expected 0", n, bus.mem_we_o); end
        checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL rnd_idle_addr[%0d]: got %h expected 0", n, bus.mem_addr_o); end
      end
      exp_rv0 = (g == 0) && !p_we[0];
      exp_rv1 = (g == 1) && !p_we[1];
      exp_err = (g >= 0) && bad;
      if (g >= 0) begin
        a = p_a[g];
        if (!p_we[g]) exp_rdata = bad ? 32'h0 : ref_read(a, p_b[g]);
        else if (!bad) begin
          if (p_b[g]) ref_mem[16'(a - START)] = p_wd[g][7:0];
          else for (int i = 0; i < 4; i++) ref_mem[16'(a + 32'(i) - START)] = p_wd[g][8*i +: 8];
        end
      end
      if (owner >= 0) begin
        if (!p_req[owner]) owner = -1;
        else if (!p_lock[owner]) begin prio = (owner == 0); owner = -1; end
      end else if (g >= 0) begin
        prio = (g == 0);
        if (p_lock[g]) owner = g;
      end
      tick();
      checks++; if (bus.rvalid0_o !== exp_rv0) begin errors++; $display("FAIL rnd_rvalid0[%0d]: got %b expected %b", n, bus.rvalid0_o, exp_rv0); end
      checks++; if (bus.rvalid1_o !== exp_rv1) begin errors++; $display("FAIL rnd_rvalid1[%0d]: got %b expected %b", n, bus.rvalid1_o, exp_rv1); end
      checks++; if (bus.err_o !== exp_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, bus.err_o, exp_err); end
      checks++; if (bus.rdata_o !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, bus.rdata_o, exp_rdata); end
      for (int k = 0; k < 2; k++) begin
        if (g == k || !p_req[k]) draw(p_req[k], p_lock[k], p_we[k], p_b[k], p_a[k], p_wd[k]);
        else if ($urandom_range(0, 15) == 0) p_req[k] = 1'b0;
      end
    end
    set_idle(); tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    set_idle();
    rst_n = 1'b0;
    tick();
    test_reset();
    test_store_load();
    test_alternate();
    test_lock();
    test_range();
    test_byte();
    test_reset_lock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
